// File: rtl/reglist_encoder_if.sv
// Handshake bundle for reglist_encoder: list load request in, one index per accept out.
// Latency/backpressure are properties of the encoder; this file only groups the signals.
// slave = encoder side, master = the driver of start/mask and consumer of index.
interface reglist_encoder_if #(
    parameter int WIDTH = 16
);
  localparam int IW = $clog2(WIDTH);

  logic             start;
  logic [WIDTH-1:0] mask;
  logic             dir;
  logic             out_valid;
  logic             out_ready;
  logic [IW-1:0]    index;
  logic             last;
  logic [IW:0]      count;
  logic             busy;
  logic             done;

  modport slave (
    input  start, mask, dir, out_ready,
    output out_valid, index, last, count, busy, done
  );

  modport master (
    output start, mask, dir, out_ready,
    input  out_valid, index, last, count, busy, done
  );
endinterface

// File: rtl/reglist_encoder.sv
// Register-list encoder: captures a WIDTH-bit mask, emits each set bit's index (REGLIST_ENCODER_DESCEND_EN adds dir).
// Latency: first index valid the cycle after start; one index per cycle while out_ready is high.
// Backpressure: out_ready low holds pending/index/last; index never depends on out_ready.
module reglist_encoder #(
    parameter int WIDTH = 16
) (
  input logic              clk,
  input logic              reset,
  reglist_encoder_if.slave bus
);
  localparam int IW = $clog2(WIDTH);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] pending_clr;
  logic [IW:0]      count_q;
  logic [IW:0]      mask_pop;
  logic             done_q;
  logic             sel_desc;
  logic [IW-1:0]    sel_idx;
  logic             sel_last;

`ifdef REGLIST_ENCODER_DESCEND_EN
  logic dir_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_q <= 1'b0;
    end else if (state == S_IDLE && bus.start) begin
      dir_q <= bus.dir;
    end
  end

  assign sel_desc = dir_q;
`else
  logic unused_dir;

  assign unused_dir = bus.dir;
  assign sel_desc   = 1'b0;
`endif

  // Priority scan: the final match wins, so scan direction picks lowest or highest.
  always_comb begin
    sel_idx = '0;
    if (sel_desc) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (pending[i]) sel_idx = IW'(i);
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (pending[i]) sel_idx = IW'(i);
      end
    end
  end

  assign sel_last    = (pending != '0) && ((pending & (pending - WIDTH'(1))) == '0);
  assign pending_clr = pending & ~(WIDTH'(1) << sel_idx);

  always_comb begin
    mask_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      mask_pop = mask_pop + (IW + 1)'(bus.mask[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      pending <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            pending <= bus.mask;
            count_q <= mask_pop;
            if (bus.mask != '0) state  <= S_RUN;
            else                done_q <= 1'b1;
          end
        end
        default: begin
          if (bus.out_ready) begin
            pending <= pending_clr;
            if (sel_last) begin
              state  <= S_IDLE;
              done_q <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.out_valid = (state == S_RUN);
  assign bus.busy      = (state == S_RUN);
  assign bus.index     = sel_idx;
  assign bus.last      = sel_last;
  assign bus.count     = count_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_reglist_encoder.sv
// Randomized/directed bench for reglist_encoder against a queue-based model of the index order.
module tb_reglist_encoder;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  reglist_encoder_if #(.WIDTH(16)) bus_if ();

  reglist_encoder #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one list and checks every cycle against the expected index queue.
  task automatic run_list(input logic [15:0] m, input logic d, input int stall_pct,
                          input logic [31:0] stall_map, input logic poke_start,
                          input string tag, output int n_cyc, output int first_idx);
    int exp_q[$];
    int exp_cnt;
    int cyc;
    for (int b = 0; b < 16; b++) begin
      if (m[b]) begin
`ifdef REGLIST_ENCODER_DESCEND_EN
        if (d) exp_q.push_front(b);
        else   exp_q.push_back(b);
`else
        exp_q.push_back(b);
`endif
      end
    end
    exp_cnt   = exp_q.size();
    first_idx = (exp_cnt != 0) ? exp_q[0] : -1;
    bus_if.start     = 1'b1;
    bus_if.mask      = m;
    bus_if.dir       = d;
    bus_if.out_ready = 1'b0;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 300) begin
      checks++;
      if ({bus_if.out_valid, bus_if.busy, bus_if.done} !== 3'b110) begin
        errors++;
        $display("FAIL %s valid/busy/done cyc %0d: got %b want 110", tag, cyc,
                 {bus_if.out_valid, bus_if.busy, bus_if.done});
      end
      checks++;
      if (int'(bus_if.index) !== exp_q[0]) begin
        errors++;
        $display("FAIL %s index cyc %0d: got %0d want %0d", tag, cyc, bus_if.index, exp_q[0]);
      end
      checks++;
      if (bus_if.last !== (exp_q.size() == 1)) begin
        errors++;
        $display("FAIL %s last cyc %0d: got %b want %b", tag, cyc, bus_if.last, exp_q.size() == 1);
      end
      checks++;
      if (int'(bus_if.count) !== exp_cnt) begin
        errors++;
        $display("FAIL %s count cyc %0d: got %0d want %0d", tag, cyc, bus_if.count, exp_cnt);
      end
      bus_if.start     = poke_start;
      bus_if.mask      = 16'($urandom);
      bus_if.dir       = 1'($urandom);
      bus_if.out_ready = !(cyc < 32 && stall_map[cyc]) && ($urandom_range(99) >= stall_pct);
      @(posedge clk); #1;
      if (bus_if.out_ready) void'(exp_q.pop_front());
      cyc++;
    end
    bus_if.start     = 1'b0;
    bus_if.out_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s timeout: %0d indices outstanding, want 0", tag, exp_q.size());
    end
    checks++;
    if ({bus_if.out_valid, bus_if.busy, bus_if.done} !== 3'b001) begin
      errors++;
      $display("FAIL %s end valid/busy/done: got %b want 001", tag,
               {bus_if.out_valid, bus_if.busy, bus_if.done});
    end
    checks++;
    if (int'(bus_if.count) !== exp_cnt || bus_if.last !== 1'b0) begin
      errors++;
      $display("FAIL %s end count/last: got %0d/%b want %0d/0", tag, bus_if.count,
               bus_if.last, exp_cnt);
    end
    n_cyc = cyc;
  endtask

  task automatic test_reset();
    checks++;
    if ({bus_if.out_valid, bus_if.busy, bus_if.done, bus_if.last, bus_if.index, bus_if.count}
        !== 13'b0) begin
      errors++;
      $display("FAIL reset outputs: got v%b b%b d%b l%b i%0d c%0d want all 0", bus_if.out_valid,
               bus_if.busy, bus_if.done, bus_if.last, bus_if.index, bus_if.count);
    end
  endtask

  task automatic test_ascend();
    int n, f;
    run_list(16'h8005, 1'b0, 0, 32'h0, 1'b0, "ascend", n, f);
    checks++;
    if (n !== 3 || f !== 0) begin
      errors++;
      $display("FAIL ascend cycles/first: got %0d/%0d want 3/0", n, f);
    end
  endtask

  task automatic test_stall();
    int n, f;
    run_list(16'h8005, 1'b0, 0, 32'h2, 1'b0, "stall", n, f);
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL stall cycles: got %0d want 4", n);
    end
  endtask

  task automatic test_empty();
    int n, f;
    run_list(16'h0000, 1'b0, 0, 32'h0, 1'b0, "empty", n, f);
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL empty cycles: got %0d want 0", n);
    end
    // Start coincides with the done pulse of the empty list.
    run_list(16'h0300, 1'b0, 0, 32'h0, 1'b0, "after_empty", n, f);
    checks++;
    if (n !== 2 || f !== 8) begin
      errors++;
      $display("FAIL after_empty cycles/first: got %0d/%0d want 2/8", n, f);
    end
  endtask

  task automatic test_reset_mid_list();
    int n, f;
    bus_if.start = 1'b1; bus_if.mask = 16'hFFFF; bus_if.dir = 1'b0; bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (bus_if.index !== 4'd5 || bus_if.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL midreset pre index/valid: got %0d/%b want 5/1", bus_if.index, bus_if.out_valid);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus_if.out_valid, bus_if.busy, bus_if.done, bus_if.last, bus_if.index, bus_if.count}
        !== 13'b0) begin
      errors++;
      $display("FAIL midreset async outputs: got v%b b%b i%0d c%0d l%b want all 0",
               bus_if.out_valid, bus_if.busy, bus_if.index, bus_if.count, bus_if.last);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    bus_if.out_ready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bus_if.done, bus_if.busy, bus_if.out_valid} !== 3'b000) begin
      errors++;
      $display("FAIL midreset no done: got %b want 000",
               {bus_if.done, bus_if.busy, bus_if.out_valid});
    end
    run_list(16'h0010, 1'b0, 0, 32'h0, 1'b0, "post_reset", n, f);
    checks++;
    if (n !== 1 || f !== 4) begin
      errors++;
      $display("FAIL post_reset cycles/first: got %0d/%0d want 1/4", n, f);
    end
  endtask

  task automatic test_start_while_busy();
    int n, f;
    run_list(16'h0A42, 1'b0, 20, 32'h0, 1'b1, "busy_start", n, f);
    checks++;
    if (f !== 1) begin
      errors++;
      $display("FAIL busy_start first: got %0d want 1", f);
    end
  endtask

  task automatic test_direction();
    int n, f, want;
`ifdef REGLIST_ENCODER_DESCEND_EN
    want = 15;
`else
    want = 0;
`endif
    run_list(16'h8005, 1'b1, 0, 32'h0, 1'b0, "dir", n, f);
    checks++;
    if (f !== want || n !== 3) begin
      errors++;
      $display("FAIL dir first/cycles: got %0d/%0d want %0d/3", f, n, want);
    end
  endtask

  task automatic test_random();
    int n, f;
    logic [15:0] m;
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(3))
        0:       m = 16'h0;
        1:       m = 16'(1 << $urandom_range(15));
        default: m = 16'($urandom);
      endcase
      run_list(m, 1'($urandom), 30, 32'h0, 1'($urandom), "random", n, f);
    end
  endtask

  initial begin
    bus_if.start = 1'b0; bus_if.mask = '0; bus_if.dir = 1'b0; bus_if.out_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    test_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    test_ascend();
    test_stall();
    test_empty();
    test_reset_mid_list();
    test_start_while_busy();
    test_direction();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
